// File: rtl/demux6_pkg.sv
// demux6_pkg: shared constants and types for the 6-way stream demux.
//   NUM_CH       number of output channels
//   SEL_W        width of the destination select code
//   sel_t        select code type
//   slot_state_e per-channel holding register state
//   sel_legal()  true when a select code names an existing channel
package demux6_pkg;

    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic sel_legal(input sel_t s);
        return s < sel_t'(NUM_CH);
    endfunction

endpackage

// File: rtl/demux6_slot.sv
// demux6_slot: one-entry register slice for a single demux output channel.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       write data_i into the slot this cycle (caller guarantees can_load_o)
//   data_i       word to store
//   ready_i      consumer takes the held word this cycle
//   valid_o      slot holds a word
//   data_o       held word (bit-stable while valid_o && !ready_i)
//   can_load_o   slot is empty or being drained this cycle
module demux6_slot
    import demux6_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [N-1:0] data_o,
    output logic         can_load_o
);

    slot_state_e  state_q, state_d;
    logic [N-1:0] data_q,  data_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a load always wins, so a drain and a load in the same
    // cycle leaves the slot FULL with the new word (no bubble).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (state_q == SLOT_FULL && ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Outputs
    always_comb begin
        valid_o    = (state_q == SLOT_FULL);
        data_o     = data_q;
        can_load_o = (state_q == SLOT_EMPTY) || ready_i;
    end

endmodule

// File: rtl/demux6_stream.sv
// demux6_stream: routes one N-bit input word to one of six registered output
// channels selected by in_sel; valid/ready on every side. Each channel has
// its own one-entry slot so a stalled consumer only blocks its own channel.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_data      word to route
//   in_sel       destination 0..5; 6..7 are accepted and dropped
//   in_valid     input word valid
//   in_ready     input word accepted this cycle (combinational)
//   out_data     channel k at [k*N +: N]
//   out_valid    bit k: channel k holds a word
//   out_ready    bit k: consumer k takes its word
//   err_count    saturating count of accepted illegal-select words
//                (present only when DEMUX6_ERR_CNT_EN is defined)
// Optional feature macro: DEMUX6_ERR_CNT_EN
module demux6_stream
    import demux6_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_data,
    input  sel_t                in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_CH*N-1:0] out_data,
    output logic [NUM_CH-1:0]   out_valid,
    input  logic [NUM_CH-1:0]   out_ready
`ifdef DEMUX6_ERR_CNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    logic [NUM_CH-1:0]     can_load;
    logic [NUM_CH-1:0]     load;
    logic [2**SEL_W-1:0]   ready_by_sel;

    // Unused select codes read as always-ready so illegal words are
    // swallowed instead of stalling the source.
    assign ready_by_sel = {{(2**SEL_W-NUM_CH){1'b1}}, can_load};
    assign in_ready     = ready_by_sel[in_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign load[k] = in_valid && in_ready && (in_sel == sel_t'(k));

        demux6_slot #(.N(N)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load[k]),
            .data_i     (in_data),
            .ready_i    (out_ready[k]),
            .valid_o    (out_valid[k]),
            .data_o     (out_data[k*N +: N]),
            .can_load_o (can_load[k])
        );
    end

`ifdef DEMUX6_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (in_valid && !sel_legal(in_sel) && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_demux6_stream.sv
module tb_demux6_stream;

    localparam int N  = 8;
    localparam int NC = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_data;
    logic [2:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [NC*N-1:0] out_data;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ready;
`ifdef DEMUX6_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    int errs   = 0;
    int checks = 0;

    // Scoreboard: one queue per channel; a slot holds at most one word, so
    // a non-empty queue also means "channel should be valid".
    logic [N-1:0] sbq[NC][$];
    int           exp_err = 0;
    bit           mon_en  = 1'b0;

    always #5 clk = ~clk;

    demux6_stream #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX6_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ch_data(input int k);
        return out_data[k*N +: N];
    endfunction

    // Inputs change 1 time unit after posedge; everything is sampled at
    // negedge, where it is stable until the next active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NC-1:0] exp_v;
            logic          exp_rdy;
            for (int k = 0; k < NC; k++) begin
                exp_v[k] = (sbq[k].size() != 0);
                if (exp_v[k] && out_valid[k])
                    chk($sformatf("data ch%0d", k), ch_data(k), sbq[k][0]);
            end
            chk("out_valid", out_valid, exp_v);
            if (in_sel < 3'd6) exp_rdy = !exp_v[in_sel] || out_ready[in_sel];
            else               exp_rdy = 1'b1;
            chk("in_ready", in_ready, exp_rdy);
`ifdef DEMUX6_ERR_CNT_EN
            chk("err_count", err_count, exp_err);
`endif
            if (rst) begin
                for (int k = 0; k < NC; k++) sbq[k].delete();
                exp_err = 0;
            end else begin
                for (int k = 0; k < NC; k++)
                    if (exp_v[k] && out_ready[k]) void'(sbq[k].pop_front());
                if (in_valid && exp_rdy) begin
                    if (in_sel < 3'd6) sbq[in_sel].push_back(in_data);
                    else if (exp_err < 255) exp_err++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = '0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst valid", out_valid, 6'b0);
        chk("rst data", out_data, 48'h0);
        mon_en = 1'b1;

        // Single word to channel 2, consumer ready
        cyc();
        out_ready = 6'h3F; in_sel = 3'd2; in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk); chk("t1 rdy", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        chk("t1 valid", out_valid, 6'b000100);
        chk("t1 data", ch_data(2), 8'hA5);
        cyc();
        @(negedge clk); chk("t1 drained", out_valid, 6'b0);

        // Channel 3 stalled: second word waits, then loads with no bubble
        cyc();
        out_ready = 6'h37; in_sel = 3'd3; in_data = 8'h11; in_valid = 1'b1;
        @(negedge clk); chk("t2 rdy1", in_ready, 1'b1);
        cyc(); in_data = 8'h22;
        @(negedge clk);
        chk("t2 rdy2", in_ready, 1'b0);
        chk("t2 hold", ch_data(3), 8'h11);
        cyc();
        @(negedge clk);
        chk("t2 hold2", ch_data(3), 8'h11);
        chk("t2 rdy3", in_ready, 1'b0);
        cyc(); out_ready[3] = 1'b1;
        @(negedge clk);
        chk("t2 rdy4", in_ready, 1'b1);
        cyc(); in_valid = 1'b0; out_ready[3] = 1'b0;
        @(negedge clk);
        chk("t2 v3", out_valid[3], 1'b1);
        chk("t2 new", ch_data(3), 8'h22);

        // Other channel passes while channel 3 stays stalled
        cyc();
        in_sel = 3'd0; in_data = 8'h5A; in_valid = 1'b1;
        @(negedge clk); chk("t3 rdy", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        chk("t3 v", out_valid, 6'b001001);
        chk("t3 d0", ch_data(0), 8'h5A);
        chk("t3 d3", ch_data(3), 8'h22);

        // Illegal select is swallowed
        cyc();
        in_sel = 3'd7; in_data = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4 rdy", in_ready, 1'b1);
            chk("t4 v", out_valid, 6'b001000);
            cyc();
        end
`ifdef DEMUX6_ERR_CNT_EN
        @(negedge clk); chk("t4 err3", err_count, 8'd3);
`endif
        in_sel = 3'd6;
        repeat (300) cyc();
        in_valid = 1'b0;
`ifdef DEMUX6_ERR_CNT_EN
        @(negedge clk); chk("t4 errsat", err_count, 8'hFF);
`endif
        chk("t4 d3", ch_data(3), 8'h22);

        // Fill all channels, then reset mid-stream
        cyc(); out_ready = 6'h08;
        cyc(); out_ready = 6'h00;
        for (int k = 0; k < NC; k++) begin
            in_sel = 3'(k); in_data = 8'(k); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5 full", out_valid, 6'h3F);
        chk("t5 d5", ch_data(5), 8'h05);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("t5 rst v", out_valid, 6'b0);
        chk("t5 rst d", out_data, 48'h0);
`ifdef DEMUX6_ERR_CNT_EN
        chk("t5 rst err", err_count, 8'd0);
`endif
        cyc(); in_sel = 3'd1; in_data = 8'h77; in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        chk("t5 v1", out_valid, 6'b000010);
        chk("t5 d1", ch_data(1), 8'h77);

        // Random traffic, scoreboard-checked every cycle
        for (int i = 0; i < 10000; i++) begin
            cyc();
            in_valid  = 1'($urandom);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = 8'($urandom);
            out_ready = 6'($urandom);
        end
        cyc(); in_valid = 1'b0; out_ready = 6'h3F;
        cyc(); cyc();
        @(negedge clk);
        for (int k = 0; k < NC; k++)
            chk($sformatf("drain ch%0d", k), 64'(sbq[k].size()), 64'd0);
        chk("drain v", out_valid, 6'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
